// File: rtl/ad9783_cfg_sequencer.sv
// rtl/ad9783_cfg_sequencer.sv - AD9783 init-table player and SPI command arbiter
// Plays the init write table after reset, then shares the controller port between host and monitor.
module ad9783_cfg_sequencer #(
  parameter int unsigned START_DLY   = 512,
  parameter int unsigned SLOT_CYCLES = 256,
  parameter int unsigned INIT_COUNT  = 2,
  parameter logic [63:0] INIT_TABLE  = 64'h0,
  parameter logic [4:0]  MON_ADDR    = 5'h06,
  parameter logic [23:0] MON_PERIOD  = 24'd1000000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        host_trig_in,
  input  logic [15:0] host_addr_in,
  input  logic [15:0] host_data_in,
  output logic [7:0]  host_data_out,
  output logic        host_done_out,
  output logic        host_err_out,
  output logic [7:0]  mon_data_out,
  output logic        mon_valid_out,
  output logic        init_done_out,
  output logic        cmd_trig_out,
  output logic [15:0] cmd_addr_out,
  output logic [15:0] cmd_data_out,
  input  logic [15:0] cmd_data_in
);
  localparam int SW = $clog2(START_DLY + 2);
  localparam int CW = $clog2(SLOT_CYCLES + 1);
  localparam logic [SW-1:0] START_LAST = SW'(START_DLY);
  localparam logic [CW-1:0] SLOT_LOAD  = CW'(SLOT_CYCLES - 1);
  localparam logic [2:0]    INIT_LAST  = 3'(INIT_COUNT);

  typedef enum logic [2:0] {
    ST_WAIT_START, ST_INIT_ISSUE, ST_INIT_WAIT, ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP
  } state_e;

  function automatic logic [15:0] entry_f(input logic [1:0] i);
    logic [63:0] t;
    t = INIT_TABLE;
    return t[{i, 4'b0000} +: 16];
  endfunction

  state_e        state_q, state_d;
  logic [SW-1:0] start_cnt_q, start_cnt_d;
  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          init_done_q, init_done_d;
  logic          host_pend_q, host_pend_d;
  logic [15:0]   host_addr_q, host_addr_d;
  logic [15:0]   host_wdat_q, host_wdat_d;
  logic          mon_pend_q, mon_pend_d;
  logic [23:0]   mon_tmr_q, mon_tmr_d;
  logic          owner_host_q, owner_host_d;
  logic [15:0]   cmd_addr_q, cmd_addr_d;
  logic [15:0]   cmd_data_q, cmd_data_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [7:0]    host_rd_q, host_rd_d;
  logic [7:0]    mon_rd_q, mon_rd_d;
  logic          host_done_q, host_done_d;
  logic          host_err_q, host_err_d;
  logic          mon_valid_q, mon_valid_d;
  logic          mon_fire;
  logic [2:0]    idx_nx;
  logic [15:0]   ent0, ent_nx;
  logic          unused_bits;

  assign idx_nx = idx_q + 3'd1;
  assign ent0   = entry_f(2'd0);
  assign ent_nx = entry_f(idx_nx[1:0]);
  assign unused_bits = ^{host_addr_in[7:5], host_data_in[15:8], cmd_data_in[15:8],
                         ent0[15:13], ent_nx[15:13]};

  always_comb begin
    state_d      = state_q;
    start_cnt_d  = start_cnt_q;
    slot_cnt_d   = slot_cnt_q;
    idx_d        = idx_q;
    init_done_d  = init_done_q;
    host_pend_d  = host_pend_q;
    host_addr_d  = host_addr_q;
    host_wdat_d  = host_wdat_q;
    mon_pend_d   = mon_pend_q;
    mon_tmr_d    = mon_tmr_q;
    owner_host_d = owner_host_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_data_d   = cmd_data_q;
    rdata_d      = rdata_q;
    host_rd_d    = host_rd_q;
    mon_rd_d     = mon_rd_q;
    host_done_d  = 1'b0;
    host_err_d   = 1'b0;
    mon_valid_d  = 1'b0;
    mon_fire     = 1'b0;

    if (init_done_q && (MON_PERIOD != 24'd0)) begin
      if (mon_tmr_q == 24'd0) begin
        mon_tmr_d = MON_PERIOD - 24'd1;
        mon_fire  = 1'b1;
      end else begin
        mon_tmr_d = mon_tmr_q - 24'd1;
      end
    end

    case (state_q)
      ST_WAIT_START: begin
        start_cnt_d = start_cnt_q + SW'(1);
        if (start_cnt_q == START_LAST) begin
          if (INIT_COUNT > 0) begin
            state_d    = ST_INIT_ISSUE;
            cmd_addr_d = {8'h21, 3'b000, ent0[12:8]};
            cmd_data_d = {8'h00, ent0[7:0]};
          end else begin
            init_done_d = 1'b1;
            mon_tmr_d   = MON_PERIOD - 24'd1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_INIT_ISSUE: begin
        slot_cnt_d = SLOT_LOAD;
        state_d    = ST_INIT_WAIT;
      end
      // Slot ends on the cycle the counter steps from 1 to 0.
      ST_INIT_WAIT: begin
        slot_cnt_d = slot_cnt_q - CW'(1);
        if (slot_cnt_q == CW'(1)) begin
          idx_d = idx_nx;
          if (idx_nx == INIT_LAST) begin
            init_done_d = 1'b1;
            mon_tmr_d   = MON_PERIOD - 24'd1;
            state_d     = ST_IDLE;
          end else begin
            state_d    = ST_INIT_ISSUE;
            cmd_addr_d = {8'h21, 3'b000, ent_nx[12:8]};
            cmd_data_d = {8'h00, ent_nx[7:0]};
          end
        end
      end
      ST_IDLE: begin
        if (host_pend_q) begin
          owner_host_d = 1'b1;
          cmd_addr_d   = host_addr_q;
          cmd_data_d   = host_wdat_q;
          state_d      = ST_ISSUE;
        end else if (mon_pend_q) begin
          owner_host_d = 1'b0;
          cmd_addr_d   = {8'h20, 3'b000, MON_ADDR};
          cmd_data_d   = 16'h0000;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        slot_cnt_d = SLOT_LOAD;
        state_d    = ST_WAIT;
        if (owner_host_q) host_pend_d = 1'b0;
        else              mon_pend_d  = 1'b0;
      end
      ST_WAIT: begin
        slot_cnt_d = slot_cnt_q - CW'(1);
        if (slot_cnt_q == CW'(1)) begin
          rdata_d = cmd_data_in[7:0];
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (owner_host_q) begin
          host_rd_d   = rdata_q;
          host_done_d = 1'b1;
        end else begin
          mon_rd_d    = rdata_q;
          mon_valid_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_WAIT_START;
    endcase

    if (mon_fire) mon_pend_d = 1'b1;

    // The slot counts as free during its own ISSUE cycle, so a strobe there is kept.
    if (host_trig_in) begin
      if ((host_addr_in[15:9] == 7'h10) &&
          (!host_pend_q || ((state_q == ST_ISSUE) && owner_host_q))) begin
        host_pend_d = 1'b1;
        host_addr_d = {host_addr_in[15:8], 3'b000, host_addr_in[4:0]};
        host_wdat_d = host_addr_in[8] ? {8'h00, host_data_in[7:0]} : 16'h0000;
      end else begin
        host_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= ST_WAIT_START;
      start_cnt_q  <= '0;
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      init_done_q  <= 1'b0;
      host_pend_q  <= 1'b0;
      host_addr_q  <= '0;
      host_wdat_q  <= '0;
      mon_pend_q   <= 1'b0;
      mon_tmr_q    <= '0;
      owner_host_q <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_data_q   <= '0;
      rdata_q      <= '0;
      host_rd_q    <= '0;
      mon_rd_q     <= '0;
      host_done_q  <= 1'b0;
      host_err_q   <= 1'b0;
      mon_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_cnt_q  <= start_cnt_d;
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      init_done_q  <= init_done_d;
      host_pend_q  <= host_pend_d;
      host_addr_q  <= host_addr_d;
      host_wdat_q  <= host_wdat_d;
      mon_pend_q   <= mon_pend_d;
      mon_tmr_q    <= mon_tmr_d;
      owner_host_q <= owner_host_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_data_q   <= cmd_data_d;
      rdata_q      <= rdata_d;
      host_rd_q    <= host_rd_d;
      mon_rd_q     <= mon_rd_d;
      host_done_q  <= host_done_d;
      host_err_q   <= host_err_d;
      mon_valid_q  <= mon_valid_d;
    end
  end

  assign cmd_trig_out  = (state_q == ST_INIT_ISSUE) || (state_q == ST_ISSUE);
  assign cmd_addr_out  = cmd_addr_q;
  assign cmd_data_out  = cmd_data_q;
  assign init_done_out = init_done_q;
  assign host_data_out = host_rd_q;
  assign host_done_out = host_done_q;
  assign host_err_out  = host_err_q;
  assign mon_data_out  = mon_rd_q;
  assign mon_valid_out = mon_valid_q;

endmodule

// File: tb/tb_ad9783_cfg_sequencer.sv
// tb/tb_ad9783_cfg_sequencer.sv - scoreboard bench for ad9783_cfg_sequencer
// dut0 covers init, host traffic and reset; dut1 covers monitor/host collision.
module tb_ad9783_cfg_sequencer;
  localparam int K_TRIG = 0, K_DONE = 1, K_ERR = 2, K_MONV = 3, K_INIT = 4;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  nvec = 0;
  int  nerr = 0;
  int  cyc0 = -1;
  int  cyc1 = -1;
  bit  done1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, h_trig0, hdone0, herr0, mv0, idn0, trig0, idn0_prev;
  logic [15:0] h_addr0, h_data0, caddr0, cdata0, ctrl0;
  logic [7:0]  hd0, md0;
  logic        rst1, h_trig1, hdone1, herr1, mv1, idn1, trig1, idn1_prev;
  logic [15:0] h_addr1, h_data1, caddr1, cdata1, ctrl1;
  logic [7:0]  hd1, md1;

  ad9783_cfg_sequencer #(
    .START_DLY(16), .SLOT_CYCLES(8), .INIT_COUNT(2),
    .INIT_TABLE(64'h0000_0000_0612_0534), .MON_ADDR(5'h06), .MON_PERIOD(24'd0)
  ) dut0 (
    .clk_in(clk), .rst_in(rst0), .host_trig_in(h_trig0), .host_addr_in(h_addr0),
    .host_data_in(h_data0), .host_data_out(hd0), .host_done_out(hdone0),
    .host_err_out(herr0), .mon_data_out(md0), .mon_valid_out(mv0),
    .init_done_out(idn0), .cmd_trig_out(trig0), .cmd_addr_out(caddr0),
    .cmd_data_out(cdata0), .cmd_data_in(ctrl0)
  );

  ad9783_cfg_sequencer #(
    .START_DLY(4), .SLOT_CYCLES(8), .INIT_COUNT(0),
    .INIT_TABLE(64'h0), .MON_ADDR(5'h06), .MON_PERIOD(24'd20)
  ) dut1 (
    .clk_in(clk), .rst_in(rst1), .host_trig_in(h_trig1), .host_addr_in(h_addr1),
    .host_data_in(h_data1), .host_data_out(hd1), .host_done_out(hdone1),
    .host_err_out(herr1), .mon_data_out(md1), .mon_valid_out(mv1),
    .init_done_out(idn1), .cmd_trig_out(trig1), .cmd_addr_out(caddr1),
    .cmd_data_out(cdata1), .cmd_data_in(ctrl1)
  );

  always @(posedge clk) begin
    cyc0 <= rst0 ? cyc0 + 1 : -1;
    cyc1 <= rst1 ? cyc1 + 1 : -1;
  end

  function automatic string kname(input int k);
    case (k)
      K_TRIG:  return "trig";
      K_DONE:  return "host_done";
      K_ERR:   return "host_err";
      K_MONV:  return "mon_valid";
      default: return "init_done";
    endcase
  endfunction

  function automatic void push(input int u, input int k, input int c,
                               input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = k; e.cyc = c; e.a = a; e.d = d;
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  task automatic chk_ev(input int u, input int k, input int c,
                        input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    nvec++;
    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      nerr++;
      $display("FAIL dut%0d unexpected_event: got %s@%0d a=%h d=%h, expected no event",
               u, kname(k), c, a, d);
      return;
    end
    if (u == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    if (e.kind != k || e.cyc != c || e.a !== a || e.d !== d) begin
      nerr++;
      $display("FAIL dut%0d event: got %s@%0d a=%h d=%h, expected %s@%0d a=%h d=%h",
               u, kname(k), c, a, d, kname(e.kind), e.cyc, e.a, e.d);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst0 === 1'b1) begin
      if (trig0)             chk_ev(0, K_TRIG, cyc0, caddr0, cdata0);
      if (hdone0)            chk_ev(0, K_DONE, cyc0, 16'h0, {8'h00, hd0});
      if (herr0)             chk_ev(0, K_ERR,  cyc0, 16'h0, 16'h0);
      if (mv0)               chk_ev(0, K_MONV, cyc0, 16'h0, {8'h00, md0});
      if (idn0 && !idn0_prev) chk_ev(0, K_INIT, cyc0, 16'h0, 16'h0);
    end
    if (rst1 === 1'b1 && cyc1 <= 44) begin
      if (trig1)             chk_ev(1, K_TRIG, cyc1, caddr1, cdata1);
      if (hdone1)            chk_ev(1, K_DONE, cyc1, 16'h0, {8'h00, hd1});
      if (herr1)             chk_ev(1, K_ERR,  cyc1, 16'h0, 16'h0);
      if (mv1)               chk_ev(1, K_MONV, cyc1, 16'h0, {8'h00, md1});
      if (idn1 && !idn1_prev) chk_ev(1, K_INIT, cyc1, 16'h0, 16'h0);
    end
    idn0_prev <= idn0;
    idn1_prev <= idn1;
  end

  task automatic wait_cyc0(input int n);
    for (int i = 0; i < 2000 && cyc0 != n; i++) begin
      @(posedge clk); #1;
    end
    if (cyc0 != n) begin
      nvec++; nerr++;
      $display("FAIL dut0 wait_cycle: got cycle %0d, expected %0d", cyc0, n);
    end
  endtask

  task automatic wait_cyc1(input int n);
    for (int i = 0; i < 2000 && cyc1 != n; i++) begin
      @(posedge clk); #1;
    end
    if (cyc1 != n) begin
      nvec++; nerr++;
      $display("FAIL dut1 wait_cycle: got cycle %0d, expected %0d", cyc1, n);
    end
  endtask

  task automatic host0(input logic [15:0] a, input logic [15:0] d);
    h_trig0 = 1'b1; h_addr0 = a; h_data0 = d;
    @(posedge clk); #1;
    h_trig0 = 1'b0;
  endtask

  task automatic host1(input logic [15:0] a, input logic [15:0] d);
    h_trig1 = 1'b1; h_addr1 = a; h_data1 = d;
    @(posedge clk); #1;
    h_trig1 = 1'b0;
  endtask

  initial begin
    rst1 = 1'b0; h_trig1 = 1'b0; h_addr1 = '0; h_data1 = '0; ctrl1 = 16'h0011;
    repeat (4) @(posedge clk);
    #1 rst1 = 1'b1;
    push(1, K_INIT, 4,  16'h0,    16'h0);
    push(1, K_TRIG, 25, 16'h2009, 16'h0000);
    push(1, K_DONE, 34, 16'h0,    16'h0011);
    push(1, K_TRIG, 35, 16'h2006, 16'h0000);
    push(1, K_MONV, 44, 16'h0,    16'h0077);
    wait_cyc1(23);
    host1(16'h2009, 16'h0000);
    wait_cyc1(38);
    ctrl1 = 16'h0077;
    wait_cyc1(50);
    done1 = 1;
  end

  initial begin
    rst0 = 1'b0; h_trig0 = 1'b0; h_addr0 = '0; h_data0 = '0; ctrl0 = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset cmd_trig", {31'b0, trig0}, 32'h0);
    chk("reset init_done", {31'b0, idn0}, 32'h0);
    chk("reset cmd_addr", {16'b0, caddr0}, 32'h0);
    chk("reset host_data", {24'b0, hd0}, 32'h0);
    @(posedge clk); #1 rst0 = 1'b1;
    push(0, K_TRIG, 16, 16'h2105, 16'h0034);
    push(0, K_TRIG, 24, 16'h2106, 16'h0012);

    wait_cyc0(27);
    rst0 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midreset cmd_trig", {31'b0, trig0}, 32'h0);
    chk("midreset init_done", {31'b0, idn0}, 32'h0);
    chk("midreset cmd_addr", {16'b0, caddr0}, 32'h0);
    chk("midreset cmd_data", {16'b0, cdata0}, 32'h0);
    push(0, K_TRIG, 16, 16'h2105, 16'h0034);
    push(0, K_TRIG, 24, 16'h2106, 16'h0012);
    push(0, K_INIT, 32, 16'h0,    16'h0);
    @(posedge clk); #1 rst0 = 1'b1;

    wait_cyc0(40);
    ctrl0 = 16'h00A5;
    push(0, K_TRIG, 42, 16'h2003, 16'h0000);
    push(0, K_DONE, 51, 16'h0,    16'h00A5);
    host0(16'h2003, 16'h1234);

    wait_cyc0(60);
    ctrl0 = 16'h0033;
    push(0, K_TRIG, 62, 16'h2107, 16'h005A);
    push(0, K_ERR,  66, 16'h0,    16'h0);
    push(0, K_ERR,  67, 16'h0,    16'h0);
    push(0, K_DONE, 71, 16'h0,    16'h0033);
    push(0, K_TRIG, 72, 16'h2001, 16'h0000);
    push(0, K_DONE, 81, 16'h0,    16'h00C3);
    host0(16'h2107, 16'hFF5A);
    wait_cyc0(64);
    host0(16'h2001, 16'h0000);
    host0(16'h2102, 16'h0011);
    host0(16'h2003, 16'h0000);
    wait_cyc0(75);
    ctrl0 = 16'h00C3;

    wait_cyc0(90);
    push(0, K_ERR, 91, 16'h0, 16'h0);
    host0(16'h2205, 16'h0000);

    wait_cyc0(120);
    for (int i = 0; i < 2000 && !done1; i++) @(posedge clk);
    nvec++;
    if (q0.size() != 0) begin
      nerr++;
      $display("FAIL dut0 pending_events: got %0d left, expected 0", q0.size());
    end
    nvec++;
    if (q1.size() != 0 || !done1) begin
      nerr++;
      $display("FAIL dut1 pending_events: got %0d left (done=%0d), expected 0", q1.size(), done1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
